// File: rtl/sprite_pkg.sv
// Shared types and default colours for the multi-sprite colour mapper.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t DEF_KEY_COLOR = 24'hFF0000;
  localparam rgb_t DEF_BG_COLOR  = 24'hFFFFFF;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    dir_t       dir;
    logic       en;
  } sprite_state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational hit test of one sprite against the current pixel.
// Produces the local pixel offset and passes the orientation through for addressing.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic [9:0]                draw_x,
  input  logic [9:0]                draw_y,
  input  sprite_state_t             spr,
  output logic                      hit,
  output logic [$clog2(SPR_W)-1:0]  off_x,
  output logic [$clog2(SPR_H)-1:0]  off_y,
  output dir_t                      dir
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [10:0] px_s;
  logic [10:0] py_s;
  logic [10:0] x0_s;
  logic [10:0] y0_s;

  // 11-bit compares keep sprites near the right/bottom edge from wrapping to 0
  assign px_s = {1'b0, draw_x};
  assign py_s = {1'b0, draw_y};
  assign x0_s = {1'b0, spr.x};
  assign y0_s = {1'b0, spr.y};

  assign hit = spr.en
             && (px_s >= x0_s) && (px_s < (x0_s + 11'(SPR_W)))
             && (py_s >= y0_s) && (py_s < (y0_s + 11'(SPR_H)));

  assign off_x = draw_x[XW-1:0] - spr.x[XW-1:0];
  assign off_y = draw_y[YW-1:0] - spr.y[YW-1:0];
  assign dir   = spr.dir;

endmodule

// File: rtl/sprite_color_mapper.sv
// Pipelined multi-sprite pixel colour generator: shadowed sprite state, priority
// hit selection, ROM fetch, colour keying and per-frame overlap reporting.
module sprite_color_mapper
  import sprite_pkg::*;
#(
  parameter int   NUM_SPRITES = 4,
  parameter int   SPR_W       = 32,
  parameter int   SPR_H       = 32,
  parameter rgb_t KEY_COLOR   = DEF_KEY_COLOR,
  parameter rgb_t BG_COLOR    = DEF_BG_COLOR,
  parameter int   ROM_AW      = 2 + $clog2(SPR_W * SPR_H)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         draw_valid,
  input  logic [NUM_SPRITES-1:0][9:0]  spr_x,
  input  logic [NUM_SPRITES-1:0][9:0]  spr_y,
  input  logic [NUM_SPRITES-1:0][1:0]  spr_dir,
  input  logic [NUM_SPRITES-1:0]       spr_en,
  output logic [ROM_AW-1:0]            rom_addr,
  input  logic [23:0]                  rom_data,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B,
  output logic                         pix_valid,
  output logic                         collision
);

  localparam int XW  = $clog2(SPR_W);
  localparam int YW  = $clog2(SPR_H);
  localparam int PIX = SPR_W * SPR_H;

  sprite_state_t           shadow_r [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  hit_s;
  logic [XW-1:0]           off_x_s  [NUM_SPRITES];
  logic [YW-1:0]           off_y_s  [NUM_SPRITES];
  dir_t                    dir_s    [NUM_SPRITES];
  logic [ROM_AW-1:0]       addr_s   [NUM_SPRITES];

  logic                    sel_hit_s;
  logic                    multi_s;
  logic [ROM_AW-1:0]       sel_addr_s;
  logic                    s1_hit_r, s1_valid_r;
  logic                    s2_hit_r, s2_valid_r;
  logic                    overlap_r;
  rgb_t                    color_s;

  // Sprite state is captured once per frame so nothing moves mid-frame
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_r[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        shadow_r[i] <= '{x: spr_x[i], y: spr_y[i], dir: dir_t'(spr_dir[i]), en: spr_en[i]};
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    sprite_hit_test #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .draw_x (DrawX),
      .draw_y (DrawY),
      .spr    (shadow_r[g]),
      .hit    (hit_s[g]),
      .off_x  (off_x_s[g]),
      .off_y  (off_y_s[g]),
      .dir    (dir_s[g])
    );
    assign addr_s[g] = (ROM_AW'(dir_s[g]) * ROM_AW'(PIX))
                     + (ROM_AW'(off_y_s[g]) << XW)
                     + ROM_AW'(off_x_s[g]);
  end

  // Lowest index wins; any further hit on the same pixel marks an overlap
  always_comb begin
    sel_hit_s  = 1'b0;
    multi_s    = 1'b0;
    sel_addr_s = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (hit_s[i] && sel_hit_s) begin
        multi_s = 1'b1;
      end else if (hit_s[i]) begin
        sel_hit_s  = 1'b1;
        sel_addr_s = addr_s[i];
      end else begin
        multi_s = multi_s;
      end
    end
  end

  // S1/S2: ROM address issue and hit/valid alignment with the ROM latency
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr   <= '0;
      s1_hit_r   <= 1'b0;
      s1_valid_r <= 1'b0;
      s2_hit_r   <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      rom_addr   <= sel_addr_s;
      s1_hit_r   <= sel_hit_s;
      s1_valid_r <= draw_valid;
      s2_hit_r   <= s1_hit_r;
      s2_valid_r <= s1_valid_r;
    end
  end

  // A transparent winner shows background, never a lower-priority sprite
  always_comb begin
    color_s = '0;
    if (!s2_valid_r) begin
      color_s = '0;
    end else if (s2_hit_r && (rom_data != KEY_COLOR)) begin
      color_s = rom_data;
    end else begin
      color_s = BG_COLOR;
    end
  end

  // S3: registered colour outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R     <= 8'd0;
      VGA_G     <= 8'd0;
      VGA_B     <= 8'd0;
      pix_valid <= 1'b0;
    end else begin
      VGA_R     <= color_s[23:16];
      VGA_G     <= color_s[15:8];
      VGA_B     <= color_s[7:0];
      pix_valid <= s2_valid_r;
    end
  end

  // An overlap seen on the frame_start cycle belongs to the frame that begins
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      overlap_r <= 1'b0;
      collision <= 1'b0;
    end else if (frame_start) begin
      collision <= overlap_r;
      overlap_r <= draw_valid & multi_s;
    end else if (draw_valid && multi_s) begin
      overlap_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed self-checking bench for sprite_color_mapper with a synchronous ROM model.
module tb_sprite_color_mapper;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              frame_start;
  logic [9:0]        DrawX, DrawY;
  logic              draw_valid;
  logic [3:0][9:0]   spr_x, spr_y;
  logic [3:0][1:0]   spr_dir;
  logic [3:0]        spr_en;
  logic [11:0]       rom_addr;
  logic [23:0]       rom_data;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              pix_valid;
  logic              collision;

  logic [23:0]       rom_mem [0:4095];
  int                n_checks = 0;
  int                n_errors = 0;
  logic [11:0]       vpat = 12'b0000_1011_0110;

  sprite_color_mapper dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .draw_valid(draw_valid),
    .spr_x(spr_x), .spr_y(spr_y), .spr_dir(spr_dir), .spr_en(spr_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid), .collision(collision)
  );

  always #5 Clk = ~Clk;

  // ROM returns data one cycle after the address
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [23:0] pat(input int a);
    logic [31:0] v;
    v = a;
    pat = {4'h7, v[11:0], 8'h3C};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outv();
    outv = {7'd0, pix_valid, VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic set_sprite(input int i, input int x, input int y, input int d, input int e);
    spr_x[i]   = 10'(x);
    spr_y[i]   = 10'(y);
    spr_dir[i] = 2'(d);
    spr_en[i]  = (e != 0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_pixel(input string tag, input int x, input int y,
                           input int exp_addr, input logic [23:0] exp_rgb);
    DrawX = 10'(x); DrawY = 10'(y); draw_valid = 1'b1;
    @(posedge Clk); #1;
    check({tag, ".addr"}, 32'(rom_addr), exp_addr);
    DrawX = 10'd0; DrawY = 10'd0; draw_valid = 1'b0;
    @(posedge Clk); #1;
    check({tag, ".lat"}, outv(), 32'd0);
    @(posedge Clk); #1;
    check({tag, ".pix"}, outv(), {8'h01, exp_rgb});
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom_mem[a] = pat(a);
    rom_mem[1125] = 24'h123456;
    rom_mem[170]  = 24'hFF0000;

    Reset = 1'b1; frame_start = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; draw_valid = 1'b0;
    spr_x = '0; spr_y = '0; spr_dir = '0; spr_en = '0;
    set_sprite(0, 0, 0, 0, 1);
    repeat (3) @(posedge Clk);
    #1;
    check("rst.out", outv(), 32'd0);
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.coll", 32'(collision), 32'd0);
    Reset = 1'b0;

    // no frame_start yet: enabled inputs must not draw
    for (int t = 0; t < 12; t++) begin
      DrawX = (t < 8) ? 10'(t * 130) : 10'd0;
      DrawY = (t < 8) ? 10'(t * 60) : 10'd0;
      draw_valid = vpat[t];
      @(posedge Clk); #1;
      check("idle.addr", 32'(rom_addr), 32'd0);
      if (t >= 2) check("idle.pix", outv(), vpat[t-2] ? 32'h01FFFFFF : 32'd0);
    end
    check("idle.coll", 32'(collision), 32'd0);

    set_sprite(0, 100, 50, 1, 1);
    frame();
    run_pixel("single", 105, 53, 1125, 24'h123456);
    run_pixel("single.corner", 131, 81, 2047, pat(2047));

    spr_x[0] = 10'd400;
    run_pixel("shadow.old", 105, 53, 1125, 24'h123456);
    frame();
    run_pixel("shadow.gone", 105, 53, 0, 24'hFFFFFF);
    run_pixel("shadow.new", 405, 53, 1125, 24'h123456);

    set_sprite(0, 190, 195, 0, 1);
    set_sprite(1, 195, 190, 2, 1);
    frame();
    run_pixel("prio.key", 200, 200, 170, 24'hFFFFFF);
    set_sprite(1, 195, 190, 2, 0);
    frame();
    run_pixel("prio.dis", 200, 200, 170, 24'hFFFFFF);
    set_sprite(0, 195, 190, 2, 1);
    set_sprite(1, 190, 195, 0, 1);
    frame();
    run_pixel("prio.swap", 200, 200, 2373, pat(2373));

    set_sprite(0, 1010, 50, 0, 1);
    set_sprite(1, 0, 0, 0, 0);
    frame();
    run_pixel("clip.wrap", 5, 53, 0, 24'hFFFFFF);
    run_pixel("clip.in", 1015, 53, 101, pat(101));
    run_pixel("clip.edge", 1023, 53, 109, pat(109));

    set_sprite(0, 300, 300, 0, 1);
    set_sprite(2, 331, 331, 0, 1);
    frame();
    frame();
    check("coll.clear", 32'(collision), 32'd0);
    run_pixel("coll.px", 331, 331, 1023, pat(1023));
    check("coll.pending", 32'(collision), 32'd0);
    frame();
    check("coll.set", 32'(collision), 32'd1);
    frame();
    check("coll.clr", 32'(collision), 32'd0);
    DrawX = 10'd331; DrawY = 10'd331; draw_valid = 1'b1; frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0; draw_valid = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    check("coll.fs", 32'(collision), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    frame();
    check("coll.late", 32'(collision), 32'd1);

    draw_valid = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("mid.pre", outv(), 32'h01FFFFFF);
    #2;
    Reset = 1'b1;
    #1;
    check("mid.async", outv(), 32'd0);
    check("mid.addr", 32'(rom_addr), 32'd0);
    check("mid.coll", 32'(collision), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk); #1;
      check("mid.resume", outv(), (k < 3) ? 32'd0 : 32'h01FFFFFF);
    end
    draw_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
